multicycle_seq_s: RTL

Multi-cycle sequencer for the RV32I core. It walks each instruction through FETCH → DECODE → EXEC → MEM → WB and drives the shared memory port, the PC, IR and register-file write enables. It decodes the 7-bit opcode held in the instruction register and uses a ready handshake on the single memory port. It also counts retired instructions and halts on an illegal opcode or a memory timeout.

---
 rtl/multicycle_seq_s.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_seq_s.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB.
// Drives the shared memory port and the PC/IR/regfile enables; halts on an illegal opcode or a memory timeout.
module multicycle_seq_s #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic [1:0]       halt_cause
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    instret_q, instret_d;
  logic                halted_q, halted_d;
  logic [1:0]          cause_q, cause_d;

  logic is_legal, is_branch, is_load, is_store, is_jal, is_jalr;
  logic wait_expired;
  logic mem_req_c, mem_we_c, addr_sel_c, ir_we_c, reg_we_c, pc_we_c;
  logic [1:0] pc_src_c;

  always_comb begin
    is_branch = (op == OP_BR);
    is_load   = (op == OP_LOAD);
    is_store  = (op == OP_STORE);
    is_jal    = (op == OP_JAL);
    is_jalr   = (op == OP_JALR);
    is_legal  = (op == OP_R) || (op == OP_IMM) || is_load || is_store || is_branch ||
                is_jal || is_jalr || (op == OP_LUI) || (op == OP_AUIPC);
  end

  // wait_q counts earlier waiting cycles, so this is the TIMEOUT-th waiting cycle
  assign wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1)) && !mem_ready;

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    instret_d  = instret_q;
    halted_d   = halted_q;
    cause_d    = cause_q;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    addr_sel_c = 1'b0;
    ir_we_c    = 1'b0;
    reg_we_c   = 1'b0;
    pc_we_c    = 1'b0;
    pc_src_c   = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          cause_d  = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (!is_legal) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          cause_d  = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_we_c   = 1'b1;
          pc_src_c  = {1'b0, branch_taken};
          instret_d = instret_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we_c   = 1'b1;
            instret_d = instret_q + CNT_W'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          cause_d  = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_we_c  = 1'b1;
        pc_we_c   = 1'b1;
        pc_src_c  = is_jal ? 2'b10 : (is_jalr ? 2'b11 : 2'b00);
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      halted_q  <= halted_d;
      cause_q   <= cause_d;
    end
  end

  // Reset aborts in-flight work immediately, including the combinational strobes
  assign mem_req    = mem_req_c  & ~rst;
  assign mem_we     = mem_we_c   & ~rst;
  assign addr_sel   = addr_sel_c & ~rst;
  assign ir_we      = ir_we_c    & ~rst;
  assign reg_we     = reg_we_c   & ~rst;
  assign pc_we      = pc_we_c    & ~rst;
  assign pc_src     = rst ? 2'b00 : pc_src_c;
  assign instret    = instret_q;
  assign halted     = halted_q;
  assign halt_cause = cause_q;

endmodule
